// File: rtl/out_arbiter_pkg.sv
// out_arbiter_pkg: shared sizing, header layout and FSM encoding for the output arbiter.
package out_arbiter_pkg;
    localparam int N_CH = 4;
    localparam int DEPTH = 8;
    localparam logic [7:0] HDR_TAG = 8'hA5;
    localparam int HDR_CH_W = 2;
    localparam int HDR_PAD_W = 6;
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY} state_t;
    function automatic logic [15:0] make_hdr(input logic [7:0] tag, input logic [HDR_CH_W-1:0] ch);
        return {tag, {HDR_PAD_W{1'b0}}, ch};
    endfunction
endpackage

// File: rtl/out_arbiter_chan_fifo.sv
// chan_fifo: per-channel show-ahead buffer; pushes into a full buffer are dropped.
module chan_fifo #(
    parameter int W = 17,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push & ~full;
    assign do_pop = pop & ~empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/out_arbiter.sv
// out_arbiter: merges per-channel packet buffers into one host FIFO stream,
// round-robin per packet, each packet prefixed by a tagged header word.
module out_arbiter #(
    parameter int N_CH = out_arbiter_pkg::N_CH,
    parameter int DEPTH = out_arbiter_pkg::DEPTH,
    parameter logic [7:0] HDR_TAG = out_arbiter_pkg::HDR_TAG
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [N_CH-1:0]    src_en,
    input  logic [16*N_CH-1:0] src_data,
    input  logic [N_CH-1:0]    src_last,
    input  logic               fifo_full,
    output logic               fifo_wr_en,
    output logic [15:0]        fifo_din,
    output logic [N_CH-1:0]    ovf,
    output logic               busy
);
    import out_arbiter_pkg::*;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(N_CH);
    state_t state, state_nxt;
    logic [GW-1:0] gnt, gnt_nxt, rr_last, rr_nxt, pick, c;
    logic [N_CH-1:0] full, empty, has_pkt, pop;
    logic [16:0] dout [N_CH];
    logic wr_nxt;
    logic [15:0] din_nxt;
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CW-1:0] pkt_cnt;
        chan_fifo #(.W(17), .DEPTH(DEPTH)) u_fifo (
            .clk(clk),
            .rst(rst),
            .push(src_en[i]),
            .din({src_last[i], src_data[16*i +: 16]}),
            .pop(pop[i]),
            .dout(dout[i]),
            .full(full[i]),
            .empty(empty[i])
        );
        // a dropped last never counts; a popped last always retires one packet
        always_ff @(posedge clk) begin
            if (rst) pkt_cnt <= '0;
            else pkt_cnt <= pkt_cnt + CW'(src_en[i] & src_last[i] & ~full[i]) - CW'(pop[i] & dout[i][16]);
        end
        assign has_pkt[i] = pkt_cnt != '0;
    end
    assign pop = (state == S_BODY && !fifo_full && !empty[gnt]) ? (N_CH'(1) << gnt) : '0;
    assign busy = state != S_IDLE;
    // scan from farthest to nearest so the channel right after rr_last wins
    always_comb begin
        pick = rr_last;
        c = rr_last;
        for (int k = N_CH; k >= 1; k--) begin
            c = rr_last + GW'(k);
            if (has_pkt[c]) pick = c;
        end
    end
    always_comb begin
        state_nxt = state;
        gnt_nxt = gnt;
        rr_nxt = rr_last;
        wr_nxt = 1'b0;
        din_nxt = fifo_din;
        case (state)
            S_IDLE: begin
                if (enable && |has_pkt) begin
                    gnt_nxt = pick;
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (!fifo_full) begin
                    wr_nxt = 1'b1;
                    din_nxt = make_hdr(HDR_TAG, gnt);
                    state_nxt = S_BODY;
                end
            end
            S_BODY: begin
                if (|pop) begin
                    wr_nxt = 1'b1;
                    din_nxt = dout[gnt][15:0];
                    if (dout[gnt][16]) begin
                        rr_nxt = gnt;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            gnt <= '0;
            rr_last <= GW'(N_CH - 1);
            fifo_wr_en <= 1'b0;
            fifo_din <= '0;
            ovf <= '0;
        end else begin
            state <= state_nxt;
            gnt <= gnt_nxt;
            rr_last <= rr_nxt;
            fifo_wr_en <= wr_nxt;
            fifo_din <= din_nxt;
            ovf <= ovf | (src_en & full);
        end
    end
endmodule

// File: tb/tb_out_arbiter.sv
// tb_out_arbiter: directed stimulus against a packet-level queue model of the arbiter.
module tb_out_arbiter;
    logic clk = 0, rst = 1, enable = 0, fifo_full = 0;
    logic [3:0] src_en = 0, src_last = 0;
    logic [63:0] src_data = 0;
    logic fifo_wr_en, busy;
    logic [15:0] fifo_din;
    logic [3:0] ovf;
    always #5 clk = ~clk;
    out_arbiter #(.N_CH(4), .DEPTH(8), .HDR_TAG(8'hA5)) dut (
        .clk(clk), .rst(rst), .enable(enable), .src_en(src_en), .src_data(src_data),
        .src_last(src_last), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din), .ovf(ovf), .busy(busy)
    );
    int checks = 0, errors = 0, cyc = 0;
    logic [16:0] mq [4][$];
    int m_pk [4];
    logic [3:0] m_ovf = 0;
    int rr_m = 3, cur = -1, last_push_cyc = 0;
    bit started = 0;
    logic full_at_edge = 0;
    logic [15:0] wr_log [$];
    int wr_cyc [$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // model: buffers as queues, words accepted while fewer than DEPTH are held
    always @(posedge clk) begin
        cyc++;
        full_at_edge = fifo_full;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mq[i].delete();
                m_pk[i] = 0;
            end
            m_ovf = 0;
            rr_m = 3;
            cur = -1;
            started = 1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (src_en[i]) begin
                    if (mq[i].size() < 8) begin
                        mq[i].push_back({src_last[i], src_data[16*i +: 16]});
                        if (src_last[i]) begin
                            m_pk[i]++;
                            last_push_cyc = cyc;
                        end
                    end else m_ovf[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        int nxt;
        logic [16:0] w;
        if (started) begin
            chk("ovf", 32'(ovf), 32'(m_ovf));
            if (fifo_wr_en === 1'b1) begin
                chk("wr_vs_full", 32'(full_at_edge), 0);
                wr_log.push_back(fifo_din);
                wr_cyc.push_back(cyc);
                if (cur < 0) begin
                    nxt = -1;
                    for (int k = 4; k >= 1; k--) if (m_pk[(rr_m + k) % 4] > 0) nxt = (rr_m + k) % 4;
                    if (nxt < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got %0h expected no write", fifo_din);
                    end else begin
                        chk("header", 32'(fifo_din), 32'({8'hA5, 6'b0, 2'(nxt)}));
                        chk("busy_in_pkt", 32'(busy), 1);
                        cur = nxt;
                    end
                end else if (mq[cur].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL underrun: got %0h expected no write from empty ch%0d", fifo_din, cur);
                end else begin
                    w = mq[cur].pop_front();
                    chk("body", 32'(fifo_din), 32'(w[15:0]));
                    if (w[16]) begin
                        m_pk[cur]--;
                        rr_m = cur;
                        cur = -1;
                        chk("busy_after_last", 32'(busy), 0);
                    end else chk("busy_in_pkt", 32'(busy), 1);
                end
            end
        end
    end

    task automatic drive(int ch, logic [15:0] d, bit last);
        src_en[ch] = 1'b1;
        src_last[ch] = last;
        src_data[16*ch +: 16] = d;
        @(negedge clk);
        src_en = 0;
        src_last = 0;
    endtask

    task automatic wait_writes(int n);
        int t = 0;
        while (wr_log.size() < n && t < 300) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++;
        if (wr_log.size() < n) begin
            errors++;
            $display("FAIL timeout: writes %0d expected %0d", wr_log.size(), n);
        end
    endtask

    task automatic settle(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_log.delete();
        wr_cyc.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_din", 32'(fifo_din), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst = 0;
        enable = 1;
        drive(0, 16'h0123, 0);
        drive(0, 16'h0456, 1);
        wait_writes(3);
        settle(3);
        chk("single_n", wr_log.size(), 3);
        chk("single_hdr", 32'(wr_log[0]), 32'h A500);
        chk("single_w0", 32'(wr_log[1]), 32'h0123);
        chk("single_w1", 32'(wr_log[2]), 32'h0456);
        chk("single_latency", 32'(wr_cyc[0] - last_push_cyc), 2);
        chk("single_b2b", 32'(wr_cyc[2] - wr_cyc[0]), 2);
        clear_log();
        src_en = 4'b1010;
        src_last = 4'b1010;
        src_data = {16'h3333, 16'h0000, 16'h1111, 16'h0000};
        @(negedge clk);
        src_en = 0;
        src_last = 0;
        wait_writes(4);
        settle(3);
        chk("rr_hdr1", 32'(wr_log[0]), 32'h A501);
        chk("rr_w1", 32'(wr_log[1]), 32'h1111);
        chk("rr_hdr3", 32'(wr_log[2]), 32'h A503);
        chk("rr_w3", 32'(wr_log[3]), 32'h3333);
        chk("rr_gap", 32'(wr_cyc[2] - wr_cyc[1]), 2);
        clear_log();
        enable = 0;
        drive(0, 16'hB001, 0);
        drive(0, 16'hB002, 0);
        drive(0, 16'hB003, 1);
        enable = 1;
        wait_writes(2);
        fifo_full = 1;
        settle(5);
        fifo_full = 0;
        wait_writes(4);
        settle(3);
        chk("bp_n", wr_log.size(), 4);
        chk("bp_w1", 32'(wr_log[2]), 32'hB002);
        chk("bp_w2", 32'(wr_log[3]), 32'hB003);
        chk("bp_stall", 32'(wr_cyc[2] - wr_cyc[1]), 6);
        clear_log();
        for (int k = 0; k < 9; k++) drive(2, 16'h2000 + 16'(k), k == 7);
        #1;
        chk("ovf_lit", 32'(ovf), 32'b0100);
        wait_writes(9);
        settle(3);
        chk("ovf_n", wr_log.size(), 9);
        chk("ovf_hdr", 32'(wr_log[0]), 32'h A502);
        chk("ovf_first", 32'(wr_log[1]), 32'h2000);
        chk("ovf_last", 32'(wr_log[8]), 32'h2007);
        clear_log();
        enable = 0;
        for (int k = 0; k < 4; k++) drive(0, 16'hC000 + 16'(k), k == 3);
        enable = 1;
        wait_writes(1);
        enable = 0;
        drive(1, 16'hD001, 1);
        settle(12);
        chk("atom_n", wr_log.size(), 5);
        chk("atom_tail", 32'(wr_log[4]), 32'hC003);
        enable = 1;
        wait_writes(7);
        settle(3);
        chk("atom_hdr1", 32'(wr_log[5]), 32'h A501);
        chk("atom_w1", 32'(wr_log[6]), 32'hD001);
        clear_log();
        drive(3, 16'hE001, 0);
        drive(3, 16'hE002, 0);
        drive(3, 16'hE003, 1);
        wait_writes(2);
        rst = 1;
        settle(1);
        chk("rst_mid_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_ovf", 32'(ovf), 0);
        rst = 0;
        settle(20);
        chk("rst_mid_quiet", wr_log.size(), 2);
        drive(1, 16'hF00F, 1);
        wait_writes(4);
        settle(3);
        chk("post_rst_hdr", 32'(wr_log[2]), 32'h A501);
        chk("post_rst_w", 32'(wr_log[3]), 32'hF00F);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/out_arbiter.md
OUT_ARBITER -- requirements
Module: out_arbiter

Interface
REQ-001 Parameter N_CH, default 4, number of channel controllers merged; fixed at 4 for this release.
REQ-002 Parameter DEPTH, default 8, words per channel buffer; power of two, >=4.
REQ-003 Parameter HDR_TAG, default 8'hA5, upper byte of every packet header word.
REQ-004 Clocking: clk  in  1  clock; reset rst, synchronous, active-high.
REQ-005 enable  in  1  arbitration enable.
REQ-006 src_en  in  N_CH  per-channel word strobe; one word per cycle, no stall possible.
REQ-007 src_data  in  16*N_CH  channel i word on bits [16i+15:16i].
REQ-008 src_last  in  N_CH  marks the final word of a packet; qualified by src_en.
REQ-009 fifo_full  in  1  host FIFO cannot accept a write this cycle.
REQ-010 fifo_wr_en  out  1  host FIFO write strobe.
REQ-011 fifo_din  out  16  host FIFO write data.
REQ-012 ovf  out  N_CH  sticky per-channel overflow flag.
REQ-013 busy  out  1  high whenever the FSM is not in S_IDLE.

Function
REQ-014 Each channel shall own a DEPTH x 17-bit buffer storing {last, data}, plus a packet counter pkt_cnt[i] (0..DEPTH).
REQ-015 src_en[i] with the buffer not full shall store the word; if src_last[i] is set, pkt_cnt[i] shall increment.
REQ-016 src_en[i] with the buffer full shall drop the word and set ovf[i]; a dropped last shall not increment pkt_cnt[i].
REQ-017 Push and pop on one channel in the same cycle shall both occur; occupancy is unchanged, and pkt_cnt[i] nets any increment and decrement.
REQ-018 FSM states: S_IDLE, S_HDR, S_BODY.
REQ-019 S_IDLE: if enable and any pkt_cnt>0, grant the first eligible channel after rr_last in round-robin order, latch it as gnt, and go to S_HDR; otherwise stay.
REQ-020 S_HDR: when !fifo_full, write {HDR_TAG, 6'b0, gnt[1:0]} and go to S_BODY; when fifo_full, hold with fifo_wr_en=0.
REQ-021 S_BODY: each cycle with !fifo_full, pop one word from gnt and write its data.
REQ-022 S_BODY: on a popped word with last=1, decrement pkt_cnt[gnt], set rr_last=gnt, and go to S_IDLE.
REQ-023 A packet shall never be interleaved with another; deasserting enable mid-packet shall complete the current packet, then idle.
REQ-024 fifo_wr_en shall be registered; fifo_wr_en=1 never coincides with fifo_full=1 sampled in the same cycle.
REQ-025 Latency: with the FIFO not full and the FSM idle, the header write shall occur at the 2nd rising edge after the edge capturing the last word; body words follow back-to-back.
REQ-026 The minimum gap between packets shall be 1 idle cycle (header, body, idle, header...).
REQ-027 ovf[i] shall clear only on rst.

Reset
REQ-028 rst shall empty all buffers, clear pkt_cnt and ovf, set fifo_wr_en=0, fifo_din=0, busy=0, state S_IDLE, and rr_last=N_CH-1 so channel 0 wins first.
REQ-029 rst asserted mid-packet shall abandon the packet with no further writes; host-side recovery is by a host FIFO flush.

Structure
REQ-030 The shared package shall hold N_CH, DEPTH, HDR_TAG, the state encoding, and the header field layout.
REQ-031 The per-channel buffer shall be a sub-module chan_fifo (17-bit, DEPTH, with full/empty and a word counter), instantiated N_CH times.

Verification
REQ-032 Single packet: ch0 pushes 16'h0123, then 16'h0456 with last, FIFO empty -> writes 16'hA500, 16'h0123, 16'h0456; header 2 edges after the last push.
REQ-033 Round-robin: ch1 and ch3 each hold one 1-word packet, rr_last=0 -> ch1 header 16'hA501 first, then ch3 header 16'hA503.
REQ-034 Backpressure: fifo_full held 5 cycles during S_BODY of a 3-word packet -> no writes while full, no word lost or duplicated, order preserved.
REQ-035 Overflow: ch2 pushes 9 words without a pop (DEPTH=8) -> 9th dropped, ovf=4'b0100; the 8 stored words are emitted once a last arrives.
REQ-036 Atomicity: ch0 starts a 4-word emission while ch1 completes a packet -> all ch0 words precede header 16'hA501.
REQ-037 Reset mid-body: rst during the 2nd body word -> fifo_wr_en=0 next cycle, busy=0, ovf=0, all buffers empty.
